// File: rtl/flash_bus_pkg.sv
// Shared definitions for the 6809-to-flash bus bridge: FSM states, bus control
// bundles for each phase, and the fill byte returned on a flash timeout.
// No logic here; latency and backpressure belong to the modules that import it.
package flash_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic spi_ce;
        logic mrdy;
        logic data_oe;
    } bus_ctl_t;

    localparam bus_ctl_t CTL_IDLE   = '{spi_ce: 1'b0, mrdy: 1'b1, data_oe: 1'b0};
    localparam bus_ctl_t CTL_ACTIVE = '{spi_ce: 1'b1, mrdy: 1'b0, data_oe: 1'b0};
    localparam bus_ctl_t CTL_DONE   = '{spi_ce: 1'b0, mrdy: 1'b1, data_oe: 1'b1};

    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: two clk cycles from input change to q.
// Backpressure: none; the input is a free-running level.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/flash_bus_bridge.sv
// Bridges 6809 reads in the flash window to a flash controller, stretching E via MRDY.
// Latency: hit path holds MRDY low ACK_WINDOW+1 clk after E rise is seen (3 clk sync).
// Backpressure: flash_ready low holds BUSY until ready returns or TIMEOUT_CYCLES expire.
module flash_bus_bridge
    import flash_bus_pkg::*;
#(
    parameter logic [3:0] BASE_NIBBLE    = 4'hF,
    parameter int          ACK_WINDOW     = 3,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_E,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_RW,
    input  logic        i_flash_ready,
    input  logic [7:0]  i_flash_data,
    output logic        o_spi_ce,
    output logic        o_MRDY,
    output logic [7:0]  o_DATA,
    output logic        o_DATA_OE,
    output logic        o_timeout
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_WINDOW);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             e_sync;
    logic             e_prev;
    logic             e_rise;
    logic             e_fall;
    logic             sel;

    state_t           state_q, state_d;
    bus_ctl_t         ctl_q, ctl_d;
    logic [7:0]       data_q, data_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0]      cyc_addr, cyc_addr_d;
    logic             unused_cyc_addr;

    sync_2ff u_sync_e (
        .clk   (clk),
        .reset (reset),
        .d     (i_E),
        .q     (e_sync)
    );

    assign e_rise = e_sync & ~e_prev;
    assign e_fall = ~e_sync & e_prev;
    assign sel    = e_rise && (i_ADDRESS_BUS[15:12] == BASE_NIBBLE) && i_RW;

    // Latched address is retained for probing; only the window nibble is decoded.
    assign unused_cyc_addr = ^cyc_addr;

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        ctl_d      = ctl_q;
        data_d     = data_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        cyc_addr_d = cyc_addr;
        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    state_d    = ST_ARM;
                    ctl_d      = CTL_ACTIVE;
                    cnt_d      = '0;
                    cyc_addr_d = i_ADDRESS_BUS;
                end
            end
            ST_ARM: begin
                if (e_fall) begin
                    state_d = ST_IDLE;
                    ctl_d   = CTL_IDLE;
                end else if (!i_flash_ready) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end else if (cnt_q >= ACK_LIM) begin
                    // Controller never went busy: same-address hit, data already valid.
                    state_d = ST_DONE;
                    ctl_d   = CTL_DONE;
                    data_d  = i_flash_data;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_BUSY: begin
                if (e_fall) begin
                    state_d = ST_IDLE;
                    ctl_d   = CTL_IDLE;
                end else if (i_flash_ready) begin
                    state_d = ST_DONE;
                    ctl_d   = CTL_DONE;
                    data_d  = i_flash_data;
                end else if (cnt_q >= TO_LIM) begin
                    state_d   = ST_DONE;
                    ctl_d     = CTL_DONE;
                    data_d    = FILL_BYTE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                if (e_fall) begin
                    state_d = ST_IDLE;
                    ctl_d   = CTL_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctl_d   = CTL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_prev    <= 1'b0;
            state_q   <= ST_IDLE;
            ctl_q     <= CTL_IDLE;
            data_q    <= FILL_BYTE;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            cyc_addr  <= '0;
        end else begin
            e_prev    <= e_sync;
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            cyc_addr  <= cyc_addr_d;
        end
    end

    assign o_spi_ce  = ctl_q.spi_ce;
    assign o_MRDY    = ctl_q.mrdy;
    assign o_DATA_OE = ctl_q.data_oe;
    assign o_DATA    = data_q;
    assign o_timeout = timeout_q;

endmodule

// File: doc/flash_bus_bridge.md
FLASH_BUS_BRIDGE -- requirements
Module: flash_bus_bridge

Interface
REQ-001 Parameter BASE_NIBBLE, default 4'hF: i_ADDRESS_BUS[15:12] value that selects the flash window.
REQ-002 Parameter ACK_WINDOW, default 3: clk cycles to wait for i_flash_ready low after o_spi_ce rises.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum clk cycles in BUSY before abort.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_E  input  1  6809 E clock, asynchronous to clk.
REQ-007 i_ADDRESS_BUS  input  16  6809 address, stable while i_E high.
REQ-008 i_RW  input  1  6809 read (1) / write (0).
REQ-009 i_flash_ready  input  1  flash controller ready; low = SPI transfer in progress.
REQ-010 i_flash_data  input  8  flash controller read data.
REQ-011 o_spi_ce  output  1  chip enable to flash controller, active high.
REQ-012 o_MRDY  output  1  6809 MRDY; low stretches E.
REQ-013 o_DATA  output  8  data to 6809 data bus.
REQ-014 o_DATA_OE  output  1  data bus output enable, high = drive o_DATA.
REQ-015 o_timeout  output  1  sticky flag, set on any BUSY timeout.

Function
REQ-016 i_E SHALL be synchronized through two flops; e_rise/e_fall SHALL be single-cycle pulses from the synchronized value.
REQ-017 A cycle SHALL be selected when e_rise occurs with i_ADDRESS_BUS[15:12]==BASE_NIBBLE and i_RW==1; the address SHALL be latched on that cycle.
REQ-018 Writes and unselected addresses SHALL leave all outputs at idle values.
REQ-019 States: IDLE, ARM, BUSY, DONE.
REQ-020 IDLE -> ARM on selected e_rise; in the same edge o_spi_ce<=1, o_MRDY<=0, ack counter cleared.
REQ-021 ARM: i_flash_ready==0 -> BUSY (timeout counter cleared); counter reaching ACK_WINDOW with i_flash_ready still 1 -> DONE (same-address hit, i_flash_data already valid).
REQ-022 BUSY: i_flash_ready==1 -> DONE; counter reaching TIMEOUT_CYCLES -> DONE with data 8'hFF and o_timeout<=1.
REQ-023 Entry to DONE SHALL capture o_DATA (i_flash_data or 8'hFF), set o_DATA_OE=1, o_MRDY=1, o_spi_ce=0.
REQ-024 DONE -> IDLE on e_fall; o_DATA_OE<=0 on that edge; o_DATA holds its last value.
REQ-025 e_fall in ARM or BUSY SHALL abort to IDLE: o_spi_ce=0, o_MRDY=1, o_DATA_OE=0, o_DATA unchanged, o_timeout unchanged.
REQ-026 e_rise while not IDLE SHALL be ignored.
REQ-027 Counters SHALL saturate, never wrap; 8 bits wide minimum.
REQ-028 Latency, hit path: o_MRDY low for ACK_WINDOW+1 clk cycles after e_rise detection.

Reset
REQ-029 reset low SHALL asynchronously force: state IDLE, o_spi_ce=0, o_MRDY=1, o_DATA=8'hFF, o_DATA_OE=0, o_timeout=0, counters and synchronizer flops 0.
REQ-030 Reset asserted mid-transfer SHALL abandon it; no data captured; o_timeout cleared only by reset.

Structure
REQ-031 State encoding, idle output values and 8'hFF fill constant SHALL live in shared package flash_bus_pkg.
REQ-032 The two-flop synchronizer SHALL be sub-module sync_2ff, instantiated once for i_E.

Verification
REQ-033 Read 0xF123, flash drops ready 2 cycles later, returns 0x5A after 40 cycles -> o_MRDY low throughout, o_DATA=0x5A, o_DATA_OE high until E falls.
REQ-034 Repeat read 0xF123, ready never drops -> DONE after ACK_WINDOW=3 cycles, o_DATA=i_flash_data, o_spi_ce pulse 4 cycles.
REQ-035 Read 0xF200, ready held low indefinitely -> after 255 BUSY cycles o_DATA=0xFF, o_timeout=1, o_MRDY=1.
REQ-036 Write to 0xF010 and read of 0x8000 -> o_spi_ce, o_DATA_OE stay 0, o_MRDY stays 1.
REQ-037 reset pulsed low during BUSY -> all outputs at reset values within same cycle, next read completes normally.
REQ-038 i_E forced low during BUSY -> IDLE next cycle, o_spi_ce=0, o_DATA unchanged.
